// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared types and constants for the Tetris VGA path.
//   color_code_t  : 3-bit board cell code, 0 = empty
//   rgb_t         : 24-bit RGB pixel value
//   PALETTE       : RGB value for each cell code
//   WALL_COLOR    : well walls and floor
//   FLASH_COLOR   : line-clear flash highlight
//   GRID_COLOR    : optional grid lines on empty cells
//   flash_state_t : line-clear flash FSM states
//   region_t      : screen region classified in pipeline stage 1
// -----------------------------------------------------------------------------
package tetris_pkg;

    typedef logic [2:0]  color_code_t;
    typedef logic [23:0] rgb_t;

    localparam rgb_t PALETTE [8] = '{
        24'h000000,   // 0 empty
        24'h00FFFF,   // 1
        24'hFFFF00,   // 2
        24'h800080,   // 3
        24'h00FF00,   // 4
        24'hFF0000,   // 5
        24'h0000FF,   // 6
        24'hFFA500    // 7
    };

    localparam rgb_t WALL_COLOR  = 24'hCCCCCC;
    localparam rgb_t FLASH_COLOR = 24'hFFFFFF;
    localparam rgb_t GRID_COLOR  = 24'h404040;

    typedef enum logic {IDLE, FLASH} flash_state_t;

    typedef enum logic [1:0] {
        REGION_OUTSIDE,
        REGION_WALL,
        REGION_INTERIOR
    } region_t;

endpackage

// File: rtl/well_flash_ctrl.sv
// -----------------------------------------------------------------------------
// well_flash_ctrl
// Line-clear flash sequencer: latches the row to flash and counts frame ticks
// until the flash has run for FLASH_FRAMES frames.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   frame_tick    : one-cycle pulse per frame, advances the flash phase
//   clear_req     : start a flash on clear_row (ignored while flashing)
//   clear_row     : board row to flash (out-of-range rows are ignored)
//   clear_busy    : high while a flash runs
//   clear_done    : one-cycle pulse on the edge the flash ends
//   flash_row     : latched row being flashed
//   flash_white   : flash running and current phase shows the highlight
// -----------------------------------------------------------------------------
module well_flash_ctrl #(
    parameter int WELL_H       = 20,
    parameter int FLASH_FRAMES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic                      clear_req,
    input  logic [$clog2(WELL_H)-1:0] clear_row,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic [$clog2(WELL_H)-1:0] flash_row,
    output logic                      flash_white
);
    import tetris_pkg::*;

    localparam int PW = $clog2(FLASH_FRAMES + 1);

    flash_state_t  state;
    logic [PW-1:0] phase;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            flash_row  <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A frame_tick arriving with the request is not counted.
                    if (clear_req && (int'(clear_row) < WELL_H)) begin
                        state     <= FLASH;
                        phase     <= '0;
                        flash_row <= clear_row;
                    end
                end
                FLASH: begin
                    if (frame_tick) begin
                        // The tick that brings phase to FLASH_FRAMES ends the flash.
                        if (phase == PW'(FLASH_FRAMES - 1)) begin
                            state      <= IDLE;
                            phase      <= '0;
                            clear_done <= 1'b1;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign clear_busy  = (state == FLASH);
    assign flash_white = (state == FLASH) && !phase[0];

endmodule

// File: rtl/well_renderer.sv
// -----------------------------------------------------------------------------
// well_renderer
// Paints the grey walls/floor of the Tetris well and the locked-piece contents
// from an internal board store, with a line-clear flash on one row.
// Two-stage pipeline, colour valid exactly 2 clocks after col/row; no stalls.
// Optional feature macro: WELL_GRID_LINES_EN draws 404040 grid lines on the
// first column/row of every empty cell.
// Ports:
//   clock, reset           : clock, asynchronous active-high reset
//   col, row               : current pixel position
//   frame_tick             : one-cycle pulse per frame
//   wr_en, wr_x, wr_y,
//   wr_code                : board cell write (out-of-range writes ignored)
//   board_clr              : clear all cells (wins over wr_en)
//   clear_req, clear_row   : start a line-clear flash on a board row
//   clear_busy, clear_done : flash in progress / end-of-flash pulse
//   color                  : RGB for the pixel presented 2 cycles earlier
// -----------------------------------------------------------------------------
module well_renderer #(
    parameter int BLOCK_SIZE   = 20,
    parameter int WELL_W       = 10,
    parameter int WELL_H       = 20,
    parameter int OFF_COL      = 100,
    parameter int OFF_ROW      = 10,
    parameter int FLASH_FRAMES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [10:0]               col,
    input  logic [10:0]               row,
    input  logic                      frame_tick,
    input  logic                      wr_en,
    input  logic [$clog2(WELL_W)-1:0] wr_x,
    input  logic [$clog2(WELL_H)-1:0] wr_y,
    input  logic [2:0]                wr_code,
    input  logic                      board_clr,
    input  logic                      clear_req,
    input  logic [$clog2(WELL_H)-1:0] clear_row,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic [23:0]               color
);
    import tetris_pkg::*;

    localparam int XW = $clog2(WELL_W);
    localparam int YW = $clog2(WELL_H);
    localparam int B  = BLOCK_SIZE;

    localparam logic [10:0] WALL_LEFT  = 11'(OFF_COL);
    localparam logic [10:0] INT_LEFT   = 11'(OFF_COL + B);
    localparam logic [10:0] INT_RIGHT  = 11'(OFF_COL + B * (WELL_W + 1) - 1);
    localparam logic [10:0] WALL_RIGHT = 11'(OFF_COL + B * (WELL_W + 2) - 1);
    localparam logic [10:0] WELL_TOP   = 11'(OFF_ROW);
    localparam logic [10:0] WELL_BOT   = 11'(OFF_ROW + B * WELL_H - 1);
    localparam logic [10:0] FLOOR_BOT  = 11'(OFF_ROW + B * (WELL_H + 1) - 1);
    localparam logic [10:0] BLK        = 11'(B);

    // ---------------- Stage 1: region and block coordinates ----------------
    region_t     region_d, region_q;
    logic [10:0] dx, dy;
    logic [XW-1:0] blk_x_q;
    logic [YW-1:0] blk_y_q;
    logic        in_frame_cols, in_int_cols, in_well_rows, in_floor_rows;

    assign dx = col - INT_LEFT;
    assign dy = row - WELL_TOP;

    assign in_frame_cols = (col >= WALL_LEFT) && (col <= WALL_RIGHT);
    assign in_int_cols   = (col >= INT_LEFT)  && (col <= INT_RIGHT);
    assign in_well_rows  = (row >= WELL_TOP)  && (row <= WELL_BOT);
    assign in_floor_rows = (row >  WELL_BOT)  && (row <= FLOOR_BOT);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        region_d = REGION_OUTSIDE;
        if (in_well_rows && in_int_cols)
            region_d = REGION_INTERIOR;
        else if ((in_well_rows || in_floor_rows) && in_frame_cols)
            region_d = REGION_WALL;
    end

`ifdef WELL_GRID_LINES_EN
    logic grid_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            region_q <= REGION_OUTSIDE;
            blk_x_q  <= '0;
            blk_y_q  <= '0;
`ifdef WELL_GRID_LINES_EN
            grid_q   <= 1'b0;
`endif
        end else begin
            region_q <= region_d;
            blk_x_q  <= XW'(dx / BLK);
            blk_y_q  <= YW'(dy / BLK);
`ifdef WELL_GRID_LINES_EN
            grid_q   <= ((dx % BLK) == '0) || ((dy % BLK) == '0);
`endif
        end
    end

    // ---------------- Board store ----------------
    color_code_t board [WELL_H][WELL_W];

    // NOTE: the board is a small flop array, not a RAM macro, so it is reset;
    // an empty well after reset is part of the block's defined behaviour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            board <= '{default: '0};
        end else if (board_clr) begin
            board <= '{default: '0};
        end else if (wr_en && (int'(wr_x) < WELL_W) && (int'(wr_y) < WELL_H)) begin
            board[wr_y][wr_x] <= wr_code;
        end
    end

    // ---------------- Flash controller ----------------
    logic [YW-1:0] flash_row;
    logic          flash_white;

    well_flash_ctrl #(
        .WELL_H       (WELL_H),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash (
        .clock       (clock),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .clear_req   (clear_req),
        .clear_row   (clear_row),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .flash_row   (flash_row),
        .flash_white (flash_white)
    );

    // ---------------- Stage 2: board read, palette, flash ----------------
    // The board is read before this edge's write lands, so a same-cycle write
    // shows up one pixel later.
    color_code_t cell_code;
    rgb_t        color_d;

    always_comb begin
        cell_code = '0;
        if (region_q == REGION_INTERIOR)
            cell_code = board[blk_y_q][blk_x_q];
    end

    always_comb begin
        color_d = '0;
        case (region_q)
            REGION_WALL: color_d = WALL_COLOR;
            REGION_INTERIOR: begin
                if (flash_white && (blk_y_q == flash_row))
                    color_d = FLASH_COLOR;
`ifdef WELL_GRID_LINES_EN
                else if (grid_q && (cell_code == '0))
                    color_d = GRID_COLOR;
`endif
                else
                    color_d = PALETTE[cell_code];
            end
            default: color_d = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) color <= '0;
        else       color <= color_d;
    end

endmodule

// File: tb/tb_well_renderer.sv
// -----------------------------------------------------------------------------
// tb_well_renderer
// Self-checking bench for well_renderer with default parameters. Pixel colour
// is checked two clocks after col/row are presented.
// -----------------------------------------------------------------------------
module tb_well_renderer;

    logic        clock;
    logic        reset;
    logic [10:0] col, row;
    logic        frame_tick;
    logic        wr_en;
    logic [3:0]  wr_x;
    logic [4:0]  wr_y;
    logic [2:0]  wr_code;
    logic        board_clr;
    logic        clear_req;
    logic [4:0]  clear_row;
    logic        clear_busy;
    logic        clear_done;
    logic [23:0] color;

    well_renderer dut (
        .clock      (clock),
        .reset      (reset),
        .col        (col),
        .row        (row),
        .frame_tick (frame_tick),
        .wr_en      (wr_en),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_code    (wr_code),
        .board_clr  (board_clr),
        .clear_req  (clear_req),
        .clear_row  (clear_row),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .color      (color)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [23:0] CC    = 24'hCCCCCC;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] CYAN  = 24'h00FFFF;
`ifdef WELL_GRID_LINES_EN
    localparam logic [23:0] E = 24'h404040;   // empty cell on a grid line
`else
    localparam logic [23:0] E = 24'h000000;
`endif

    typedef struct {
        string       name;
        logic [10:0] c;
        logic [10:0] r;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input int c, input int r, input logic [23:0] exp);
        vec_t v;
        v.name = name;
        v.c    = 11'(c);
        v.r    = 11'(r);
        v.exp  = exp;
        vecs.push_back(v);
    endfunction

    task automatic sample_pixel(input int c, input int r, output logic [23:0] px);
        @(negedge clock);
        col = 11'(c);
        row = 11'(r);
        @(negedge clock);
        @(negedge clock);
        px = color;
    endtask

    task automatic pix_check(input string name, input int c, input int r, input logic [23:0] exp);
        logic [23:0] px;
        sample_pixel(c, r, px);
        check(name, 32'(px), 32'(exp));
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            pix_check(vecs[i].name, int'(vecs[i].c), int'(vecs[i].r), vecs[i].exp);
    endtask

    task automatic write_cell(input int x, input int y, input int code);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_x    = 4'(x);
        wr_y    = 5'(y);
        wr_code = 3'(code);
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic tick();
        @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
    endtask

    initial begin
        int g_reset, g_cell, g_floor, g_clr, g_end;

        // Vector table: {name, col, row, expected colour}
        g_reset = 0;
        add("left_of_wall",   99,  25, 24'h0);
        add("wall_left_first",100, 25, CC);
        add("wall_left_last", 119, 25, CC);
        add("interior_first", 120, 25, E);
        add("interior_last",  319, 25, 24'h0);
        add("wall_right_first",320,25, CC);
        add("wall_right_last",339, 25, CC);
        add("right_of_wall",  340, 25, 24'h0);
        g_cell = vecs.size();
        add("cell00_topleft", 120, 10, CYAN);
        add("cell00_botright",139, 29, CYAN);
        add("cell10_empty",   140, 10, E);
        add("cell01_empty",   120, 30, E);
        g_floor = vecs.size();
        add("floor_left",     100, 410, CC);
        add("floor_right",    339, 429, CC);
        add("floor_past_right",340,410, 24'h0);
        add("below_floor",    200, 430, 24'h0);
        add("floor_left_out", 99,  429, 24'h0);
        add("last_int_row",   200, 409, E);
        g_clr = vecs.size();
        add("clr_cell23",     165, 75,  24'h0);
        add("clr_cell55",     225, 115, 24'h0);
        add("clr_cell00",     125, 15,  24'h0);
        add("grid_corner",    120, 10,  E);
        add("grid_inside",    121, 11,  24'h0);
        g_end = vecs.size();

        reset      = 1'b1;
        col        = '0;
        row        = '0;
        frame_tick = 1'b0;
        wr_en      = 1'b0;
        wr_x       = '0;
        wr_y       = '0;
        wr_code    = '0;
        board_clr  = 1'b0;
        clear_req  = 1'b0;
        clear_row  = '0;

        // Reset state
        #1;
        check("reset_color", 32'(color), 32'h0);
        check("reset_busy",  32'(clear_busy), 32'h0);
        check("reset_done",  32'(clear_done), 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        apply(g_reset, g_cell - 1);

        // Cell write, and out-of-range writes that must be ignored
        write_cell(0, 0, 1);
        write_cell(10, 0, 3);
        write_cell(0, 20, 4);
        apply(g_cell, g_floor - 1);

        // Write timing: same-cycle read sees old value, next pixel sees new
        @(negedge clock);
        col = 11'd140;
        row = 11'd10;
        @(negedge clock);
        wr_en = 1'b1; wr_x = 4'd1; wr_y = 5'd0; wr_code = 3'd2;
        @(negedge clock);
        wr_en = 1'b0;
        check("wr_same_cycle_old", 32'(color), 32'(E));
        @(negedge clock);
        check("wr_next_cycle_new", 32'(color), 32'hFFFF00);

        apply(g_floor, g_clr - 1);

        // Fill row 19 with code 5
        for (int x = 0; x < 10; x++) write_cell(x, 19, 5);
        pix_check("row19_filled", 200, 409, RED);

        // Idle ignores out-of-range row and stray frame ticks
        @(negedge clock);
        clear_req = 1'b1; clear_row = 5'd20;
        @(negedge clock);
        clear_req = 1'b0;
        check("bad_row_ignored", 32'(clear_busy), 32'h0);
        tick();
        check("idle_tick_ignored", 32'(clear_busy), 32'h0);

        // Full flash on row 19
        @(negedge clock);
        clear_req = 1'b1; clear_row = 5'd19;
        @(negedge clock);
        clear_req = 1'b0;
        check("flash_busy", 32'(clear_busy), 32'h1);
        pix_check("flash_phase0", 150, 400, WHITE);
        tick();
        pix_check("flash_phase1", 150, 400, RED);
        tick();
        @(negedge clock);
        clear_req = 1'b1; clear_row = 5'd0;
        @(negedge clock);
        clear_req = 1'b0;
        pix_check("flash_phase2", 150, 400, WHITE);
        pix_check("flash_req_ignored", 120, 10, CYAN);
        tick();
        pix_check("flash_phase3", 150, 400, RED);
        check("no_early_done", 32'(clear_done), 32'h0);
        @(negedge clock);
        frame_tick = 1'b1;
        @(posedge clock);
        #1;
        check("done_pulse", 32'(clear_done), 32'h1);
        check("busy_drop",  32'(clear_busy), 32'h0);
        @(negedge clock);
        frame_tick = 1'b0;
        @(posedge clock);
        #1;
        check("done_one_cycle", 32'(clear_done), 32'h0);
        pix_check("after_flash", 150, 400, RED);

        // Request with coincident tick: phase stays 0; then reset at phase 2
        @(negedge clock);
        clear_req = 1'b1; frame_tick = 1'b1; clear_row = 5'd19;
        @(negedge clock);
        clear_req = 1'b0; frame_tick = 1'b0;
        check("req_tick_busy", 32'(clear_busy), 32'h1);
        pix_check("req_tick_phase0", 150, 400, WHITE);
        tick();
        tick();
        pix_check("second_phase2", 150, 400, WHITE);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_busy",  32'(clear_busy), 32'h0);
        check("midreset_done",  32'(clear_done), 32'h0);
        check("midreset_color", 32'(color), 32'h0);
        @(negedge clock);
        check("midreset_done_hold", 32'(clear_done), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check("postreset_done", 32'(clear_done), 32'h0);

        // board_clr wins over a coincident write
        write_cell(2, 3, 4);
        write_cell(0, 0, 1);
        pix_check("pre_clr_cell23", 165, 75, 24'h00FF00);
        @(negedge clock);
        board_clr = 1'b1;
        wr_en = 1'b1; wr_x = 4'd5; wr_y = 5'd5; wr_code = 3'd6;
        @(negedge clock);
        board_clr = 1'b0;
        wr_en = 1'b0;
        apply(g_clr, g_end - 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
